// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: coprocessor-0 for the pipelined MIPS core.
// Holds SR, Cause, EPC, PRId, BadVAddr, Count and Compare. Decides whether the
// instruction committing in the memory stage traps, either on an interrupt or
// on a synchronous exception, and serves mfc0/mtc0 accesses.
module cp0_timer_ctrl #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID      = 32'h25000000,
    parameter bit          TIMER_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_badvaddr,
    input  logic                 wr_en,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 eret,
    output logic [31:0]          rdata,
    output logic                 irq_take,
    output logic [31:0]          epc_out,
    output logic                 timer_irq
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    logic        sr_ie;
    logic        sr_exl;
    logic [5:0]  sr_im;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;

    logic [5:0]  pend;
    logic        int_req;
    logic        exc_req;
    logic        mtc0_ok;
    logic [31:0] epc_next;
    logic        timer_pend;

    // Live pending vector: external lines in the low bits, timer folded onto bit 5.
    assign timer_pend = TIMER_EN & timer_irq;
    assign pend       = 6'(hwint) | {timer_pend, 5'b00000};

    assign int_req  = sr_ie & ~sr_exl & (|(pend & sr_im));
    assign exc_req  = (exc_code != 5'd0) & ~sr_exl;
    assign irq_take = int_req | exc_req;

    // A trap always beats a software write in the same cycle.
    assign mtc0_ok  = wr_en & ~irq_take;

    // Restart address: the branch itself when the trapping instruction sits in its delay slot.
    assign epc_next = {exc_pc[31:2], 2'b00} - (exc_bd ? 32'd4 : 32'd0);

    assign epc_out  = epc;

    // mfc0 read mux; unmapped register numbers read as zero.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            REG_BADVADDR: rdata = badvaddr;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_SR:       rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            REG_CAUSE:    rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};
            REG_EPC:      rdata = epc;
            REG_PRID:     rdata = PRID;
            default:      rdata = 32'd0;
        endcase
    end

    // Count/Compare timer: free-running counter with a sticky match flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 32'd0;
            compare   <= 32'd0;
            timer_irq <= 1'b0;
        end else begin
            if (mtc0_ok && addr == REG_COUNT)
                count <= wdata;
            else
                count <= count + 32'd1;

            if (mtc0_ok && addr == REG_COMPARE) begin
                compare   <= wdata;
                timer_irq <= 1'b0;
            end else if (count == compare && compare != 32'd0) begin
                timer_irq <= 1'b1;
            end
        end
    end

    // Status/Cause/EPC/BadVAddr: trap entry, eret and mtc0 updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_ie     <= 1'b0;
            sr_exl    <= 1'b0;
            sr_im     <= 6'd0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
            badvaddr  <= 32'd0;
        end else begin
            cause_ip <= pend;
            if (irq_take) begin
                sr_exl    <= 1'b1;
                cause_bd  <= exc_bd;
                cause_exc <= int_req ? 5'd0 : exc_code;
                epc       <= epc_next;
                if (!int_req && (exc_code == 5'd4 || exc_code == 5'd5))
                    badvaddr <= exc_badvaddr;
            end else begin
                if (eret)
                    sr_exl <= 1'b0;
                if (mtc0_ok && addr == REG_SR) begin
                    sr_im  <= wdata[15:10];
                    sr_exl <= wdata[1];
                    sr_ie  <= wdata[0];
                end
                if (mtc0_ok && addr == REG_EPC)
                    epc <= wdata;
            end
        end
    end

endmodule
